vadd_dispatch: RTL and testbench

- Sequences a bank of NUM_UNITS vadd lanes within one personality.
- Splits a vector add of length fplen into contiguous per-lane slices and launches all lanes together.
- Waits for every lane's sum_vld, reduces the lane sums into one 64-bit total with sticky error flags, then releases the lanes back to idle.

---
 rtl/vadd_dispatch_if.sv | 43 ++++
 rtl/vadd_dispatch.sv | 147 ++++++++++++++
 tb/tb_vadd_dispatch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_dispatch_if.sv
// Bundle between the vadd dispatcher, its host and its bank of vadd lanes.
// The host pulses start only while busy is low; done pulses for one cycle with sum and flags valid.
interface vadd_dispatch_if #(
    parameter int NUM_UNITS = 4
);
    logic                      start;
    logic [47:0]               mem_offset;
    logic [31:0]               fplen;
    logic                      busy;
    logic                      done;
    logic [63:0]               sum;
    logic                      sum_ovrflw;
    logic                      res_ovrflw;
    logic                      rsp_invalid_fp;
    logic                      rsp_tid_err;
    logic [NUM_UNITS-1:0]      unit_start;
    logic [NUM_UNITS-1:0]      unit_idle;
    logic [48*NUM_UNITS-1:0]   unit_offset;
    logic [32*NUM_UNITS-1:0]   unit_fplen;
    logic [64*NUM_UNITS-1:0]   unit_sum;
    logic [NUM_UNITS-1:0]      unit_sum_vld;
    logic [NUM_UNITS-1:0]      unit_sum_ovrflw;
    logic [NUM_UNITS-1:0]      unit_res_ovrflw;
    logic [NUM_UNITS-1:0]      unit_invalid_fp;
    logic [NUM_UNITS-1:0]      unit_tid_err;
    logic [2:0]                state_dbg;

    modport master (
        output start, mem_offset, fplen,
        output unit_sum, unit_sum_vld, unit_sum_ovrflw, unit_res_ovrflw,
        output unit_invalid_fp, unit_tid_err,
        input  busy, done, sum, sum_ovrflw, res_ovrflw, rsp_invalid_fp, rsp_tid_err,
        input  unit_start, unit_idle, unit_offset, unit_fplen, state_dbg
    );

    modport slave (
        input  start, mem_offset, fplen,
        input  unit_sum, unit_sum_vld, unit_sum_ovrflw, unit_res_ovrflw,
        input  unit_invalid_fp, unit_tid_err,
        output busy, done, sum, sum_ovrflw, res_ovrflw, rsp_invalid_fp, rsp_tid_err,
        output unit_start, unit_idle, unit_offset, unit_fplen, state_dbg
    );
endinterface

// File: rtl/vadd_dispatch.sv
// Splits one vector add across NUM_UNITS vadd lanes, launches them together,
// then reduces the lane sums into a single 64-bit total with sticky error flags.
module vadd_dispatch #(
    parameter int NUM_UNITS = 4,
    parameter int LOG_UNITS = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    vadd_dispatch_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        LAUNCH   = 3'd2,
        WAIT_SUM = 3'd3,
        REDUCE   = 3'd4,
        RELEASE  = 3'd5
    } state_t;

    localparam int IDX_W = (LOG_UNITS > 0) ? LOG_UNITS : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    state_t               state;
    logic [47:0]          cap_offset;
    logic [31:0]          cap_fplen;
    logic [NUM_UNITS-1:0] vld_mask;
    logic [1:0]           wait_cnt;
    logic [IDX_W-1:0]     idx;
    logic [64:0]          acc;
    logic                 ovf;

    logic [31:0]          chunk;
    logic [47:0]          stride;
    logic [NUM_UNITS-1:0] mask_next;
    logic [63:0]          lane_sum;
    logic                 lane_ovf;
    logic [64:0]          add;

    always_comb begin
        chunk     = cap_fplen >> LOG_UNITS;
        stride    = {13'd0, chunk, 3'd0};
        mask_next = vld_mask | bus.unit_sum_vld;
        lane_sum  = bus.unit_sum[{idx, 6'd0} +: 64];
        lane_ovf  = bus.unit_sum_ovrflw[idx];
        add       = {1'b0, acc[63:0]} + {1'b0, lane_sum};
    end

    assign bus.state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            cap_offset         <= '0;
            cap_fplen          <= '0;
            vld_mask           <= '0;
            wait_cnt           <= '0;
            idx                <= '0;
            acc                <= '0;
            ovf                <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.sum            <= '0;
            bus.sum_ovrflw     <= 1'b0;
            bus.res_ovrflw     <= 1'b0;
            bus.rsp_invalid_fp <= 1'b0;
            bus.rsp_tid_err    <= 1'b0;
            bus.unit_start     <= '0;
            bus.unit_idle      <= '1;
            bus.unit_offset    <= '0;
            bus.unit_fplen     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cap_offset         <= bus.mem_offset;
                        cap_fplen          <= bus.fplen;
                        vld_mask           <= '0;
                        acc                <= '0;
                        ovf                <= 1'b0;
                        bus.sum            <= '0;
                        bus.sum_ovrflw     <= 1'b0;
                        bus.res_ovrflw     <= 1'b0;
                        bus.rsp_invalid_fp <= 1'b0;
                        bus.rsp_tid_err    <= 1'b0;
                        bus.busy           <= 1'b1;
                        state              <= CALC;
                    end
                end
                CALC: begin
                    // The last lane also absorbs the remainder that does not divide evenly.
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        bus.unit_offset[48*i +: 48] <= cap_offset + stride * 48'(i);
                        if (i == NUM_UNITS - 1)
                            bus.unit_fplen[32*i +: 32] <= chunk + (cap_fplen & 32'(NUM_UNITS - 1));
                        else
                            bus.unit_fplen[32*i +: 32] <= chunk;
                    end
                    bus.unit_start <= '1;
                    bus.unit_idle  <= '0;
                    state          <= LAUNCH;
                end
                LAUNCH: begin
                    bus.unit_start <= '0;
                    wait_cnt       <= '0;
                    state          <= WAIT_SUM;
                end
                WAIT_SUM: begin
                    bus.res_ovrflw     <= bus.res_ovrflw     | (|bus.unit_res_ovrflw);
                    bus.rsp_invalid_fp <= bus.rsp_invalid_fp | (|bus.unit_invalid_fp);
                    bus.rsp_tid_err    <= bus.rsp_tid_err    | (|bus.unit_tid_err);
                    // Lanes still show the previous run's sum_vld until they leave idle.
                    if (wait_cnt != 2'd2) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else begin
                        vld_mask <= mask_next;
                        if (&mask_next) begin
                            idx   <= '0;
                            state <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    bus.res_ovrflw     <= bus.res_ovrflw     | (|bus.unit_res_ovrflw);
                    bus.rsp_invalid_fp <= bus.rsp_invalid_fp | (|bus.unit_invalid_fp);
                    bus.rsp_tid_err    <= bus.rsp_tid_err    | (|bus.unit_tid_err);
                    acc <= add;
                    ovf <= ovf | add[64] | lane_ovf;
                    if (idx == LAST_IDX) begin
                        bus.sum        <= add[63:0];
                        bus.sum_ovrflw <= ovf | add[64] | lane_ovf;
                        bus.done       <= 1'b1;
                        bus.unit_idle  <= '1;
                        state          <= RELEASE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RELEASE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vadd_dispatch.sv
// Bench for vadd_dispatch: drives whole vector-add runs through a lane model
// and scores each done pulse against a queue of predicted results.
module tb_vadd_dispatch;
    localparam int NU = 4;
    localparam logic [NU-1:0] ALL = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vadd_dispatch_if #(.NUM_UNITS(NU)) bus ();
    vadd_dispatch #(.NUM_UNITS(NU), .LOG_UNITS(2)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [64:0] exp_q[$];

    logic [63:0]   lane_sum[NU];
    int            lane_dly[NU];
    logic [NU-1:0] lane_sovf, lane_rovf, lane_inv;
    int            tid_pulse_lane;
    bit            glitch_start;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done must match the oldest predicted result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            check("exp_q_depth_at_done", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("sum", bus.sum, e[63:0]);
                check("sum_ovrflw", 64'(bus.sum_ovrflw), 64'(e[64]));
            end
        end
    end

    task automatic idle_inputs;
        bus.start           = 1'b0;
        bus.mem_offset      = '0;
        bus.fplen           = '0;
        bus.unit_sum        = '0;
        bus.unit_sum_vld    = '0;
        bus.unit_sum_ovrflw = '0;
        bus.unit_res_ovrflw = '0;
        bus.unit_invalid_fp = '0;
        bus.unit_tid_err    = '0;
    endtask

    task automatic run_op(input logic [47:0] off, input logic [31:0] len);
        logic [64:0]   acc, tmp;
        logic          ovf;
        logic [31:0]   chunk, ef;
        logic [47:0]   eo;
        logic [NU-1:0] seen;
        int            k, n;
        acc = '0;
        ovf = 1'b0;
        for (int i = 0; i < NU; i++) begin
            tmp = {1'b0, acc[63:0]} + {1'b0, lane_sum[i]};
            ovf = ovf | tmp[64] | lane_sovf[i];
            acc = tmp;
        end
        exp_q.push_back({ovf, acc[63:0]});
        for (int i = 0; i < NU; i++) bus.unit_sum[64*i +: 64] = lane_sum[i];
        bus.unit_sum_ovrflw = lane_sovf;
        bus.unit_res_ovrflw = lane_rovf;
        bus.unit_invalid_fp = lane_inv;
        bus.unit_tid_err    = '0;
        bus.mem_offset = off;
        bus.fplen      = len;
        bus.start      = 1'b1;
        tick;
        bus.start = 1'b0;
        check("busy_calc", 64'(bus.busy), 64'd1);
        check("ustart_calc", 64'(bus.unit_start), 64'd0);
        tick;
        check("ustart_cycle2", 64'(bus.unit_start), 64'(ALL));
        check("uidle_launch", 64'(bus.unit_idle), 64'd0);
        check("tid_cleared", 64'(bus.rsp_tid_err), 64'd0);
        check("sum_cleared", bus.sum, 64'd0);
        chunk = len >> 2;
        for (int i = 0; i < NU; i++) begin
            eo = off + 48'(i) * 48'(chunk) * 48'd8;
            ef = (i == NU - 1) ? chunk + (len & 32'd3) : chunk;
            check($sformatf("unit_offset%0d", i), 64'(bus.unit_offset[48*i +: 48]), 64'(eo));
            check($sformatf("unit_fplen%0d", i), 64'(bus.unit_fplen[32*i +: 32]), 64'(ef));
        end
        tick;
        check("ustart_pulse_end", 64'(bus.unit_start), 64'd0);
        tick;
        tick;
        // Stale sum_vld from the previous run was held through LAUNCH and the first two wait cycles.
        seen = '0;
        k = 0;
        while (seen != ALL && k < 50) begin
            for (int i = 0; i < NU; i++) if (lane_dly[i] == k) seen[i] = 1'b1;
            bus.unit_sum_vld = seen;
            if (tid_pulse_lane >= 0 && k == 0) bus.unit_tid_err = NU'(1) << tid_pulse_lane;
            if (glitch_start && k == 0) bus.start = 1'b1;
            tick;
            bus.start        = 1'b0;
            bus.unit_tid_err = '0;
            if (glitch_start && k == 0) check("ignored_start_ustart", 64'(bus.unit_start), 64'd0);
            k++;
        end
        n = 1;
        while (!bus.done && n < 30) begin
            tick;
            n++;
        end
        check("done_latency", 64'(n), 64'd5);
        check("uidle_release", 64'(bus.unit_idle), 64'(ALL));
        check("res_ovrflw", 64'(bus.res_ovrflw), 64'(|lane_rovf));
        check("rsp_invalid_fp", 64'(bus.rsp_invalid_fp), 64'(|lane_inv));
        check("rsp_tid_err", 64'(bus.rsp_tid_err), 64'(tid_pulse_lane >= 0));
        tick;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        tick;
        check("tid_sticky_idle", 64'(bus.rsp_tid_err), 64'(tid_pulse_lane >= 0));
        check("sum_held", bus.sum, acc[63:0]);
    endtask

    task automatic clear_lanes;
        for (int i = 0; i < NU; i++) begin
            lane_sum[i] = '0;
            lane_dly[i] = 0;
        end
        lane_sovf      = '0;
        lane_rovf      = '0;
        lane_inv       = '0;
        tid_pulse_lane = -1;
        glitch_start   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        idle_inputs();
        clear_lanes();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_uidle", 64'(bus.unit_idle), 64'(ALL));
        check("rst_ustart", 64'(bus.unit_start), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        rst_n = 1'b1;
        tick;

        // Uneven split, lanes finishing out of order with two on one cycle.
        clear_lanes();
        lane_sum = '{64'd1, 64'd2, 64'd3, 64'd4};
        lane_dly = '{1, 3, 1, 0};
        run_op(48'h1000, 32'd10);

        // Zero-length vector.
        clear_lanes();
        run_op(48'h4000, 32'd0);

        // Reduction wrap plus a one-cycle tid error pulse.
        clear_lanes();
        lane_sum = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0};
        lane_dly = '{0, 2, 1, 0};
        tid_pulse_lane = 1;
        run_op(48'h8000, 32'd64);

        // Fewer elements than lanes, start pulsed while waiting.
        clear_lanes();
        lane_sum = '{64'd7, 64'd0, 64'd0, 64'd9};
        lane_dly = '{2, 0, 1, 3};
        glitch_start = 1'b1;
        run_op(48'hABC, 32'd3);

        // Offsets wrapping past the top of the 48-bit space.
        clear_lanes();
        lane_sum = '{64'd5, 64'd6, 64'd7, 64'd8};
        lane_sovf = 4'b0100;
        run_op(48'hFFFF_FFFF_FF00, 32'h103);

        for (int r = 0; r < 4; r++) begin
            clear_lanes();
            for (int i = 0; i < NU; i++) begin
                lane_sum[i] = {$urandom, $urandom};
                lane_dly[i] = $urandom_range(0, 6);
            end
            lane_rovf = NU'($urandom_range(0, 15));
            lane_inv  = NU'($urandom_range(0, 15));
            run_op({$urandom, $urandom}, 32'($urandom_range(0, 300)));
        end

        // Reset during REDUCE: abort with no done.
        clear_lanes();
        dc = done_cnt;
        bus.mem_offset = 48'h2000;
        bus.fplen      = 32'd8;
        bus.unit_sum   = {4{64'h1234}};
        bus.unit_sum_vld = '0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        bus.unit_sum_vld = ALL;
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_uidle", 64'(bus.unit_idle), 64'(ALL));
        check("abort_ufplen", 64'(|bus.unit_fplen), 64'd0);
        check("abort_uoffset", 64'(|bus.unit_offset), 64'd0);
        check("abort_sum", bus.sum, 64'd0);
        check("abort_state", 64'(bus.state_dbg), 64'd0);
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (8) tick;
        check("abort_no_done", 64'(done_cnt), 64'(dc));

        // Recovery run after the abort.
        clear_lanes();
        lane_sum = '{64'd100, 64'd200, 64'd300, 64'd400};
        lane_dly = '{3, 2, 1, 0};
        run_op(48'h10, 32'd17);

        repeat (3) tick;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
